// File: rtl/stage_wb.sv
`default_nettype none
// ============================================================================
// Module      : stage_wb
// Description : MEM/WB pipeline register and writeback stage. Selects the
//               writeback source, suppresses writes to x0, detects
//               store-data forwarding from WB into MEM and counts retired
//               instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_wb (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        stall,
    input  logic        flush,
    input  logic        me_valid,
    input  logic [31:0] me_alu_o,
    input  logic [31:0] me_mem_data,
    input  logic [4:0]  me_rd,
    input  logic        me_regs_write,
    input  logic        me_mem2reg,
    input  logic        me_mem_write,
    input  logic [4:0]  me_rs2,
    output logic [31:0] w_regs_data,
    output logic [4:0]  w_rd,
    output logic        w_regs_write,
    output logic        forward_data,
    output logic [63:0] instret
);

    logic        wb_valid;
    logic [31:0] wb_alu_o;
    logic [31:0] wb_mem_data;
    logic [4:0]  wb_rd;
    logic        wb_regs_write;
    logic        wb_mem2reg;
    logic [63:0] instret_q;

    // An instruction retires into WB only when it is live and actually captured.
    logic retire;
    assign retire = me_valid & ~stall & ~flush;

    // MEM/WB register: flush kills validity but still captures payload; stall holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid      <= 1'b0;
            wb_alu_o      <= 32'd0;
            wb_mem_data   <= 32'd0;
            wb_rd         <= 5'd0;
            wb_regs_write <= 1'b0;
            wb_mem2reg    <= 1'b0;
        end else if (flush || !stall) begin
            wb_valid      <= me_valid & ~flush;
            wb_alu_o      <= me_alu_o;
            wb_mem_data   <= me_mem_data;
            wb_rd         <= me_rd;
            wb_regs_write <= me_regs_write;
            wb_mem2reg    <= me_mem2reg;
        end
    end

    // Retired-instruction counter; wraps silently at 2^64.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= 64'd0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret      = instret_q;
    assign w_regs_data  = wb_mem2reg ? wb_mem_data : wb_alu_o;
    assign w_rd         = wb_rd;
    // x0 is hard-wired to zero, so a write to it is never issued.
    assign w_regs_write = wb_valid & wb_regs_write & (wb_rd != 5'd0);
    // Store in MEM reads the register WB is writing this cycle: use WB data.
    assign forward_data = me_valid & me_mem_write & w_regs_write & (w_rd == me_rs2);

endmodule
`default_nettype wire

// File: tb/tb_stage_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_wb
// Description : Directed self-checking testbench for stage_wb.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stage_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        me_valid;
    logic [31:0] me_alu_o;
    logic [31:0] me_mem_data;
    logic [4:0]  me_rd;
    logic        me_regs_write;
    logic        me_mem2reg;
    logic        me_mem_write;
    logic [4:0]  me_rs2;
    logic [31:0] w_regs_data;
    logic [4:0]  w_rd;
    logic        w_regs_write;
    logic        forward_data;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    stage_wb dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .me_valid     (me_valid),
        .me_alu_o     (me_alu_o),
        .me_mem_data  (me_mem_data),
        .me_rd        (me_rd),
        .me_regs_write(me_regs_write),
        .me_mem2reg   (me_mem2reg),
        .me_mem_write (me_mem_write),
        .me_rs2       (me_rs2),
        .w_regs_data  (w_regs_data),
        .w_rd         (w_rd),
        .w_regs_write (w_regs_write),
        .forward_data (forward_data),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge and let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_me(input logic v, input logic [31:0] alu, input logic [31:0] md,
                          input logic [4:0] rd, input logic rw, input logic m2r,
                          input logic mw, input logic [4:0] rs2);
        me_valid = v; me_alu_o = alu; me_mem_data = md; me_rd = rd;
        me_regs_write = rw; me_mem2reg = m2r; me_mem_write = mw; me_rs2 = rs2;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        set_me(1'b1, 32'hAAAA_5555, 32'h1111_2222, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9);
        #2;
        checks++; if (w_regs_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", w_regs_data); end
        checks++; if (w_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", w_rd); end
        checks++; if (w_regs_write !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", w_regs_write); end
        checks++; if (forward_data !== 1'b0) begin errors++; $display("FAIL reset_fwd: got %b expected 0", forward_data); end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %h expected 0", instret); end
        step();
        set_me(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_alu_wb();
        set_me(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0);
        step();
        checks++; if (w_regs_data !== 32'h0000_1234) begin errors++; $display("FAIL alu_data: got %h expected 00001234", w_regs_data); end
        checks++; if (w_rd !== 5'd5) begin errors++; $display("FAIL alu_rd: got %0d expected 5", w_rd); end
        checks++; if (w_regs_write !== 1'b1) begin errors++; $display("FAIL alu_we: got %b expected 1", w_regs_write); end
        checks++; if (instret !== 64'd1) begin errors++; $display("FAIL alu_instret: got %0d expected 1", instret); end
    endtask

    task automatic test_load_wb();
        set_me(1'b1, 32'h0000_0040, 32'hFFFF_FF80, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0);
        step();
        checks++; if (w_regs_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL load_data: got %h expected ffffff80", w_regs_data); end
        checks++; if (w_rd !== 5'd7) begin errors++; $display("FAIL load_rd: got %0d expected 7", w_rd); end
        checks++; if (instret !== 64'd2) begin errors++; $display("FAIL load_instret: got %0d expected 2", instret); end
    endtask

    task automatic test_forward();
        set_me(1'b1, 32'hDEAD_BEEF, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0);
        step();
        set_me(1'b1, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 5'd9);
        #1;
        checks++; if (forward_data !== 1'b1) begin errors++; $display("FAIL fwd_match: got %b expected 1", forward_data); end
        checks++; if (w_regs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fwd_data: got %h expected deadbeef", w_regs_data); end
        me_rs2 = 5'd8; #1;
        checks++; if (forward_data !== 1'b0) begin errors++; $display("FAIL fwd_rs2_mismatch: got %b expected 0", forward_data); end
        me_rs2 = 5'd9; me_mem_write = 1'b0; #1;
        checks++; if (forward_data !== 1'b0) begin errors++; $display("FAIL fwd_not_store: got %b expected 0", forward_data); end
        me_mem_write = 1'b1; me_valid = 1'b0; #1;
        checks++; if (forward_data !== 1'b0) begin errors++; $display("FAIL fwd_not_valid: got %b expected 0", forward_data); end
        // WB now writes x0: no write enable, no forwarding even with rs2=0.
        set_me(1'b1, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        step();
        set_me(1'b1, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 5'd0);
        #1;
        checks++; if (w_regs_write !== 1'b0) begin errors++; $display("FAIL x0_we: got %b expected 0", w_regs_write); end
        checks++; if (forward_data !== 1'b0) begin errors++; $display("FAIL x0_fwd: got %b expected 0", forward_data); end
        checks++; if (instret !== 64'd4) begin errors++; $display("FAIL fwd_instret: got %0d expected 4", instret); end
    endtask

    task automatic test_stall_flush();
        set_me(1'b1, 32'h0000_0111, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_me(1'b1, 32'hA000 + i, 32'hB000 + i, 5'(10 + i), 1'b1, 1'(i & 1), 1'b0, 5'd0);
            step();
            checks++; if (w_regs_data !== 32'h0000_0111) begin errors++; $display("FAIL stall_data[%0d]: got %h expected 00000111", i, w_regs_data); end
            checks++; if (w_rd !== 5'd3) begin errors++; $display("FAIL stall_rd[%0d]: got %0d expected 3", i, w_rd); end
            checks++; if (w_regs_write !== 1'b1) begin errors++; $display("FAIL stall_we[%0d]: got %b expected 1", i, w_regs_write); end
            checks++; if (instret !== 64'd5) begin errors++; $display("FAIL stall_instret[%0d]: got %0d expected 5", i, instret); end
        end
        flush = 1'b1;
        set_me(1'b1, 32'h0000_0222, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0);
        step();
        checks++; if (w_regs_write !== 1'b0) begin errors++; $display("FAIL flush_we: got %b expected 0", w_regs_write); end
        checks++; if (w_rd !== 5'd4) begin errors++; $display("FAIL flush_rd: got %0d expected 4", w_rd); end
        checks++; if (w_regs_data !== 32'h0000_0222) begin errors++; $display("FAIL flush_data: got %h expected 00000222", w_regs_data); end
        checks++; if (instret !== 64'd5) begin errors++; $display("FAIL flush_instret: got %0d expected 5", instret); end
        stall = 1'b0; flush = 1'b0;
        set_me(1'b1, 32'h0000_0333, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0);
        step();
        checks++; if (w_regs_write !== 1'b1) begin errors++; $display("FAIL resume_we: got %b expected 1", w_regs_write); end
        checks++; if (instret !== 64'd6) begin errors++; $display("FAIL resume_instret: got %0d expected 6", instret); end
    endtask

    task automatic test_wrap();
        set_me(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        step();
        checks++; if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_hold: got %h expected ffffffffffffffff", instret); end
        me_valid = 1'b1;
        step();
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL wrap_zero: got %h expected 0", instret); end
    endtask

    task automatic test_async_reset();
        set_me(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0);
        step();
        checks++; if (w_regs_write !== 1'b1) begin errors++; $display("FAIL pre_reset_we: got %b expected 1", w_regs_write); end
        #2;
        stall = 1'b1; flush = 1'b1;
        set_me(1'b1, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 5'd5);
        rst = 1'b0;
        #1;
        checks++; if (w_regs_data !== 32'd0) begin errors++; $display("FAIL arst_data: got %h expected 00000000", w_regs_data); end
        checks++; if (w_rd !== 5'd0) begin errors++; $display("FAIL arst_rd: got %0d expected 0", w_rd); end
        checks++; if (w_regs_write !== 1'b0) begin errors++; $display("FAIL arst_we: got %b expected 0", w_regs_write); end
        checks++; if (forward_data !== 1'b0) begin errors++; $display("FAIL arst_fwd: got %b expected 0", forward_data); end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL arst_instret: got %h expected 0", instret); end
        step();
        checks++; if (instret !== 64'd0 || w_regs_write !== 1'b0) begin errors++; $display("FAIL arst_held: instret %h we %b expected 0 0", instret, w_regs_write); end
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_me(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0);
        step();
        checks++; if (w_regs_data !== 32'h0000_1234) begin errors++; $display("FAIL post_rst_data: got %h expected 00001234", w_regs_data); end
        checks++; if (w_rd !== 5'd5) begin errors++; $display("FAIL post_rst_rd: got %0d expected 5", w_rd); end
        checks++; if (w_regs_write !== 1'b1) begin errors++; $display("FAIL post_rst_we: got %b expected 1", w_regs_write); end
        checks++; if (instret !== 64'd1) begin errors++; $display("FAIL post_rst_instret: got %0d expected 1", instret); end
    endtask

    initial begin
        test_reset();
        test_alu_wb();
        test_load_wb();
        test_forward();
        test_stall_flush();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_wb.md
STAGE_WB -- requirements
Module: stage_wb

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-low reset; one clock; no other clock or reset.
REQ-003 stall  input  1  hold the MEM/WB register contents this cycle.
REQ-004 flush  input  1  kill the instruction entering WB this cycle.
REQ-005 me_valid  input  1  MEM stage holds a live instruction.
REQ-006 me_alu_o  input  32  ALU result / memory address from MEM.
REQ-007 me_mem_data  input  32  extended load data from MEM.
REQ-008 me_rd  input  5  destination register index.
REQ-009 me_regs_write  input  1  instruction writes rd.
REQ-010 me_mem2reg  input  1  writeback source is load data (1) or ALU result (0).
REQ-011 me_mem_write  input  1  MEM instruction is a store.
REQ-012 me_rs2  input  5  store-data source register of the MEM instruction.
REQ-013 w_regs_data  output  32  writeback data to the register file.
REQ-014 w_rd  output  5  writeback destination index.
REQ-015 w_regs_write  output  1  register-file write enable.
REQ-016 forward_data  output  1  select w_regs_data as store data in MEM.
REQ-017 instret  output  64  retired-instruction counter.

Function
REQ-018 The MEM/WB register SHALL hold wb_valid, wb_alu_o, wb_mem_data, wb_rd, wb_regs_write and wb_mem2reg, all updated only on a rising clk edge.
REQ-019 When flush=1, the register SHALL set wb_valid to 0 and capture the other fields normally; flush SHALL take priority over stall.
REQ-020 When flush=0 and stall=1, the register SHALL keep all fields unchanged.
REQ-021 When flush=0 and stall=0, the register SHALL capture all me_* fields, with wb_valid taken from me_valid.
REQ-022 Latency SHALL be one cycle from a MEM-stage capture to the corresponding WB outputs.
REQ-023 w_regs_data SHALL be combinational: wb_mem_data when wb_mem2reg=1, otherwise wb_alu_o.
REQ-024 w_rd SHALL equal wb_rd.
REQ-025 w_regs_write SHALL equal wb_valid AND wb_regs_write AND (wb_rd != 0); a write to x0 SHALL never be issued.
REQ-026 forward_data SHALL be combinational and equal me_valid AND me_mem_write AND w_regs_write AND (w_rd == me_rs2).
REQ-027 forward_data SHALL be 0 whenever me_rs2=0, as a consequence of REQ-025.
REQ-028 instret SHALL increment by 1 on each edge where me_valid=1, stall=0 and flush=0; it SHALL hold otherwise.
REQ-029 instret SHALL wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-030 A stalled instruction SHALL be counted exactly once, on the edge where it is actually captured.
REQ-031 While stall=1, the WB outputs SHALL remain stable and w_regs_write SHALL repeat the same write; register-file rewrite of identical data is acceptable.

Reset
REQ-032 While rst=0, all MEM/WB fields and instret SHALL clear to 0 immediately, regardless of clk.
REQ-033 Reset clearing SHALL force w_regs_data=0, w_rd=0, w_regs_write=0 and forward_data=0.
REQ-034 Reset asserted mid-stall or mid-flush SHALL override both.
REQ-035 Capture SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-036 Stimulus: ALU writeback with me_alu_o=0x0000_1234, me_rd=5, me_regs_write=1, me_mem2reg=0, me_valid=1. Required next cycle: w_regs_data=0x1234, w_rd=5, w_regs_write=1, instret=1.
REQ-037 Stimulus: load writeback with me_mem_data=0xFFFF_FF80, me_alu_o=0x40, me_mem2reg=1, rd=7. Required next cycle: w_regs_data=0xFFFF_FF80.
REQ-038 Stimulus: store forwarding with WB writing x9=0xDEAD_BEEF while MEM has me_mem_write=1, me_rs2=9. Required: forward_data=1. Repeat with rs2=8 or rd=0: forward_data=0.
REQ-039 Stimulus: stall=1 for 3 cycles with changing me_* inputs. Required: WB outputs and instret unchanged. Then stall=flush=1: w_regs_write=0 next cycle and instret unchanged.
REQ-040 Stimulus: counter preloaded to 0xFFFF_FFFF_FFFF_FFFF via 2^64-1 captures (or forced in the bench), then one valid capture. Required: instret=0.
REQ-041 Stimulus: rst pulled low between clock edges during active writeback. Required: all outputs 0 before the next edge; first post-reset capture behaves per REQ-036.
